swc_pmem_write_pump_db: RTL and testbench

Parametrised, double-buffered write pump for the switch packet memory. It packs G_RATIO narrow input words of G_DATA_WIDTH bits into one wide memory line and generates the line address within the current page. Completed lines are written only in the time slot marked by sync_i. A second (holding) line register lets input continue while a finished line waits for its slot. Each written line carries a per-word valid mask, so flushed partial lines are identifiable.

---
 rtl/swc_pmem_write_pump_db.sv | 130 +++++++++++++
 tb/tb_swc_pmem_write_pump_db.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swc_pmem_write_pump_db.sv
// Double-buffered write pump: packs G_RATIO narrow words into one memory line,
// parks finished lines in a holding register and writes them in the sync_i slot.
module swc_pmem_write_pump_db #(
    parameter int G_DATA_WIDTH      = 32,
    parameter int G_RATIO           = 16,
    parameter int G_PAGE_ADDR_WIDTH = 10,
    parameter int G_LINE_ADDR_WIDTH = 3
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [G_PAGE_ADDR_WIDTH-1:0]                 pgaddr_i,
    input  logic                                         pgreq_i,
    input  logic [G_DATA_WIDTH-1:0]                      d_i,
    input  logic                                         drdy_i,
    input  logic                                         flush_i,
    input  logic                                         sync_i,
    output logic                                         full_o,
    output logic [G_DATA_WIDTH*G_RATIO-1:0]              q_o,
    output logic [G_RATIO-1:0]                           mask_o,
    output logic [G_PAGE_ADDR_WIDTH+G_LINE_ADDR_WIDTH-1:0] addr_o,
    output logic                                         we_o,
    output logic                                         pgend_o
);
    localparam int CW = $clog2(G_RATIO);
    localparam int LW = G_DATA_WIDTH * G_RATIO;
    localparam int AW = G_PAGE_ADDR_WIDTH + G_LINE_ADDR_WIDTH;

    logic [CW-1:0]                cnt_reg;
    logic [LW-1:0]                acc_data_reg;
    logic [G_RATIO-1:0]           acc_mask_reg;
    logic                         acc_closed_reg;
    logic                         hold_valid_reg;
    logic [LW-1:0]                hold_data_reg;
    logic [G_RATIO-1:0]           hold_mask_reg;
    logic [AW-1:0]                hold_addr_reg;
    logic [G_PAGE_ADDR_WIDTH-1:0] page_reg;
    logic [G_LINE_ADDR_WIDTH-1:0] line_reg;
    logic [LW-1:0]                q_reg;
    logic [G_RATIO-1:0]           mask_reg;
    logic [AW-1:0]                addr_reg;
    logic                         we_reg;
    logic                         pgend_reg;

    logic                         accept;
    logic                         last_word;
    logic                         close_now;
    logic                         drain;
    logic                         transfer;
    logic [G_RATIO-1:0]           slot_hit;
    logic [LW-1:0]                acc_data_w;
    logic [G_RATIO-1:0]           acc_mask_w;

    // A closed accumulator refuses input until its line reaches the holding register.
    assign accept    = drdy_i & ~acc_closed_reg;
    assign last_word = accept & (cnt_reg == CW'(G_RATIO - 1));
    assign drain     = sync_i & hold_valid_reg;
    assign close_now = acc_closed_reg | last_word | (flush_i & (|acc_mask_w));
    assign transfer  = close_now & (~hold_valid_reg | drain);

    // Accumulator contents including the word accepted this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < G_RATIO; gi++) begin : g_slot
            assign slot_hit[gi] = accept & (cnt_reg == CW'(gi));
            assign acc_data_w[gi*G_DATA_WIDTH +: G_DATA_WIDTH] =
                slot_hit[gi] ? d_i : acc_data_reg[gi*G_DATA_WIDTH +: G_DATA_WIDTH];
            assign acc_mask_w[gi] = acc_mask_reg[gi] | slot_hit[gi];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg        <= '0;
            acc_data_reg   <= '0;
            acc_mask_reg   <= '0;
            acc_closed_reg <= 1'b0;
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
            hold_mask_reg  <= '0;
            hold_addr_reg  <= '0;
            page_reg       <= '0;
            line_reg       <= '0;
            q_reg          <= '0;
            mask_reg       <= '0;
            addr_reg       <= '0;
            we_reg         <= 1'b0;
            pgend_reg      <= 1'b0;
        end else begin
            we_reg    <= drain;
            pgend_reg <= drain & (&hold_addr_reg[G_LINE_ADDR_WIDTH-1:0]);
            if (drain) begin
                q_reg          <= hold_data_reg;
                mask_reg       <= hold_mask_reg;
                addr_reg       <= hold_addr_reg;
                hold_valid_reg <= 1'b0;
            end
            // A reload on the drain edge overrides the hold_valid clear above.
            if (transfer) begin
                hold_valid_reg <= 1'b1;
                hold_data_reg  <= acc_data_w;
                hold_mask_reg  <= acc_mask_w;
                hold_addr_reg  <= {page_reg, line_reg};
                line_reg       <= line_reg + 1'b1;
                acc_data_reg   <= '0;
                acc_mask_reg   <= '0;
                cnt_reg        <= '0;
                acc_closed_reg <= 1'b0;
            end else begin
                acc_data_reg <= acc_data_w;
                acc_mask_reg <= acc_mask_w;
                if (accept)
                    cnt_reg <= cnt_reg + 1'b1;
                if (close_now)
                    acc_closed_reg <= 1'b1;
            end
            // The transfer above already captured the old address; the new page starts at line 0.
            if (pgreq_i) begin
                page_reg <= pgaddr_i;
                line_reg <= '0;
            end
        end
    end

    assign full_o  = acc_closed_reg;
    assign q_o     = q_reg;
    assign mask_o  = mask_reg;
    assign addr_o  = addr_reg;
    assign we_o    = we_reg;
    assign pgend_o = pgend_reg;
endmodule

// File: tb/tb_swc_pmem_write_pump_db.sv
// Scoreboard bench for swc_pmem_write_pump_db: stimulus pushes expected lines,
// a negedge monitor pops and compares on every we_o.
module tb_swc_pmem_write_pump_db;
    localparam int DW  = 32;
    localparam int R   = 16;
    localparam int PAW = 10;
    localparam int LAW = 3;
    localparam int LW  = DW * R;
    localparam int AW  = PAW + LAW;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic [PAW-1:0] pgaddr_i = '0;
    logic           pgreq_i = 1'b0;
    logic [DW-1:0]  d_i = '0;
    logic           drdy_i = 1'b0;
    logic           flush_i = 1'b0;
    logic           sync_i;
    logic           full_o;
    logic [LW-1:0]  q_o;
    logic [R-1:0]   mask_o;
    logic [AW-1:0]  addr_o;
    logic           we_o;
    logic           pgend_o;

    swc_pmem_write_pump_db #(
        .G_DATA_WIDTH(DW), .G_RATIO(R),
        .G_PAGE_ADDR_WIDTH(PAW), .G_LINE_ADDR_WIDTH(LAW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .pgaddr_i(pgaddr_i), .pgreq_i(pgreq_i),
        .d_i(d_i), .drdy_i(drdy_i), .flush_i(flush_i), .sync_i(sync_i),
        .full_o(full_o), .q_o(q_o), .mask_o(mask_o), .addr_o(addr_o),
        .we_o(we_o), .pgend_o(pgend_o)
    );

    always #5 clk = ~clk;

    // sync source: 0 = off, 1 = periodic every 16 cycles, 2 = manual
    int   sync_mode = 0;
    logic sync_man  = 1'b0;
    logic per_pulse = 1'b0;
    int   cyc = 0;
    assign sync_i = (sync_mode == 1) ? per_pulse : ((sync_mode == 2) ? sync_man : 1'b0);

    always @(negedge clk) begin
        cyc++;
        per_pulse = ((cyc % 16) == 0);
    end

    typedef struct {
        logic [LW-1:0] q;
        logic [R-1:0]  m;
        logic [AW-1:0] a;
        logic          pe;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    always @(negedge clk) begin
        if (we_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_we addr got=%h mask got=%h (no line expected)", addr_o, mask_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (q_o !== mon_e.q || mask_o !== mon_e.m || addr_o !== mon_e.a || pgend_o !== mon_e.pe) begin
                    errors++;
                    $display("FAIL line addr got=%h exp=%h mask got=%h exp=%h pgend got=%b exp=%b q got=%h exp=%h",
                             addr_o, mon_e.a, mask_o, mon_e.m, pgend_o, mon_e.pe, q_o, mon_e.q);
                end else begin
                    $display("line ok addr=%h mask=%h pgend=%b", addr_o, mask_o, pgend_o);
                end
            end
        end
    end

    task automatic push_exp(input logic [LW-1:0] q, input logic [R-1:0] m,
                            input logic [AW-1:0] a, input logic pe);
        exp_t e;
        e.q = q; e.m = m; e.a = a; e.pe = pe;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end else begin
            $display("check ok %s = %0h", name, got);
        end
    endtask

    task automatic write_word(input logic [DW-1:0] d, input logic fl);
        int n;
        @(negedge clk);
        drdy_i  = 1'b1;
        d_i     = d;
        flush_i = fl;
        n = 0;
        while (full_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL write_timeout full got=%b exp=0", full_o);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        drdy_i  = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic flush_only();
        @(negedge clk);
        drdy_i  = 1'b0;
        flush_i = 1'b1;
        @(posedge clk);
        idle();
    endtask

    task automatic do_pgreq(input logic [PAW-1:0] p);
        @(negedge clk);
        pgreq_i  = 1'b1;
        pgaddr_i = p;
        @(negedge clk);
        pgreq_i  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending got=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    logic [LW-1:0] e;

    initial begin
        #12;
        chk("reset_full", full_o, 0);
        chk("reset_we", we_o, 0);
        chk("reset_q", q_o, 0);
        chk("reset_mask", mask_o, 0);
        chk("reset_addr", addr_o, 0);
        chk("reset_pgend", pgend_o, 0);
        @(negedge clk);
        rst_i = 1'b0;

        // full line on page 3
        sync_mode = 1;
        do_pgreq(10'd3);
        e = '0;
        for (int k = 0; k < R; k++) e[k*DW +: DW] = DW'(k);
        push_exp(e, 16'hFFFF, {10'd3, 3'd0}, 1'b0);
        for (int k = 0; k < R; k++) write_word(DW'(k), 1'b0);
        idle();
        wait_drain();

        // partial line closed by a separate flush
        e = '0;
        for (int k = 0; k < 5; k++) e[k*DW +: DW] = 32'hA0 + DW'(k);
        push_exp(e, 16'h001F, {10'd3, 3'd1}, 1'b0);
        for (int k = 0; k < 5; k++) write_word(32'hA0 + DW'(k), 1'b0);
        idle();
        flush_only();
        wait_drain();

        // flush on an empty accumulator must not write anything
        flush_only();
        repeat (20) @(negedge clk);

        // flush coinciding with an accepted word
        e = '0;
        e[0*DW +: DW] = 32'hB0;
        e[1*DW +: DW] = 32'hB1;
        push_exp(e, 16'h0003, {10'd3, 3'd2}, 1'b0);
        write_word(32'hB0, 1'b0);
        write_word(32'hB1, 1'b1);
        idle();
        wait_drain();

        // asynchronous reset while a line is held and another is closed
        sync_mode = 0;
        for (int k = 0; k < 2 * R; k++) write_word(32'hC0 + DW'(k), 1'b0);
        #1;
        chk("pre_reset_full", full_o, 1);
        idle();
        @(posedge clk);
        #3;
        rst_i = 1'b1;
        #1;
        chk("midrst_full", full_o, 0);
        chk("midrst_q", q_o, 0);
        chk("midrst_mask", mask_o, 0);
        chk("midrst_addr", addr_o, 0);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        sync_mode = 1;
        repeat (40) @(negedge clk);

        // backpressure: two lines with no sync slot, third word stalled
        sync_mode = 2;
        sync_man  = 1'b0;
        do_pgreq(10'd2);
        e = '0;
        for (int k = 0; k < R; k++) e[k*DW +: DW] = 32'd100 + DW'(k);
        push_exp(e, 16'hFFFF, {10'd2, 3'd0}, 1'b0);
        e = '0;
        for (int k = 0; k < R; k++) e[k*DW +: DW] = 32'd200 + DW'(k);
        push_exp(e, 16'hFFFF, {10'd2, 3'd1}, 1'b0);
        for (int k = 0; k < R; k++) write_word(32'd100 + DW'(k), 1'b0);
        for (int k = 0; k < R; k++) write_word(32'd200 + DW'(k), 1'b0);
        #1;
        chk("bp_full_set", full_o, 1);
        @(negedge clk);
        drdy_i = 1'b1;
        d_i    = 32'h33;
        repeat (3) @(negedge clk);
        chk("bp_full_holds", full_o, 1);
        sync_man = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_full_clear", full_o, 0);
        e = '0;
        e[0 +: DW] = 32'h33;
        push_exp(e, 16'h0001, {10'd2, 3'd2}, 1'b0);
        @(negedge clk);
        sync_man = 1'b0;
        @(posedge clk);
        @(negedge clk);
        drdy_i  = 1'b0;
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        sync_mode = 1;
        wait_drain();

        // page wrap: nine lines on page 5
        do_pgreq(10'd5);
        for (int l = 0; l < 9; l++) begin
            e = '0;
            for (int k = 0; k < R; k++) e[k*DW +: DW] = (DW'(l) << 16) | DW'(k);
            push_exp(e, 16'hFFFF, {10'd5, 3'(l)}, (l == 7));
        end
        for (int l = 0; l < 9; l++)
            for (int k = 0; k < R; k++) write_word((DW'(l) << 16) | DW'(k), 1'b0);
        idle();
        wait_drain();

        // collision: close, drain and pgreq on the same edge
        sync_mode = 2;
        sync_man  = 1'b0;
        e = '0;
        for (int k = 0; k < R; k++) e[k*DW +: DW] = 32'h500 + DW'(k);
        push_exp(e, 16'hFFFF, {10'd5, 3'd1}, 1'b0);
        e = '0;
        for (int k = 0; k < R; k++) e[k*DW +: DW] = 32'h600 + DW'(k);
        push_exp(e, 16'hFFFF, {10'd5, 3'd2}, 1'b0);
        for (int k = 0; k < R; k++) write_word(32'h500 + DW'(k), 1'b0);
        for (int k = 0; k < R - 1; k++) write_word(32'h600 + DW'(k), 1'b0);
        @(negedge clk);
        drdy_i   = 1'b1;
        d_i      = 32'h60F;
        sync_man = 1'b1;
        pgreq_i  = 1'b1;
        pgaddr_i = 10'd9;
        @(negedge clk);
        drdy_i   = 1'b0;
        sync_man = 1'b0;
        pgreq_i  = 1'b0;
        e = '0;
        e[0 +: DW] = 32'h700;
        push_exp(e, 16'h0001, {10'd9, 3'd0}, 1'b0);
        write_word(32'h700, 1'b1);
        idle();
        sync_mode = 1;
        wait_drain();

        repeat (20) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
